// File: rtl/seg_display_driver_pkg.sv
// Shared constants, FSM state type and digit pattern table for the 7-segment driver.
package seg_display_driver_pkg;

  // Active-low segment patterns {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    UPDATE = 2'd2
  } state_t;

  // 16-entry digit pattern table, 0..9 then A..F
  function automatic logic [6:0] digitPattern(input logic [3:0] nibble);
    logic [6:0] pat;
    pat = SEG_BLANK;
    case (nibble)
      4'h0: pat = 7'b1000000;
      4'h1: pat = 7'b1111001;
      4'h2: pat = 7'b0100100;
      4'h3: pat = 7'b0110000;
      4'h4: pat = 7'b0011001;
      4'h5: pat = 7'b0010010;
      4'h6: pat = 7'b0000010;
      4'h7: pat = 7'b1111000;
      4'h8: pat = 7'b0000000;
      4'h9: pat = 7'b0010000;
      4'hA: pat = 7'b0001000;
      4'hB: pat = 7'b0000011;
      4'hC: pat = 7'b1000110;
      4'hD: pat = 7'b0100001;
      4'hE: pat = 7'b0000110;
      4'hF: pat = 7'b0001110;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg_display_driver_hex7_decode.sv
// Combinational 4-bit nibble to active-low 7-segment pattern decoder.
module hex7_decode
  import seg_display_driver_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  // Straight table lookup, no state
  always_comb begin
    o_seg = digitPattern(i_nibble);
  end

endmodule

// File: rtl/seg_display_driver.sv
// Multi-digit 7-segment driver: binary value to decimal (double-dabble) or hex digits,
// with leading-zero blanking and an all-dash overflow indication.
module seg_display_driver
  import seg_display_driver_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int BIN_WIDTH     = 14,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    load,
  input  logic [BIN_WIDTH-1:0]    value,
  input  logic                    mode_hex,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [7*NUM_DIGITS-1:0] seg_out
);

  // One extra BCD nibble so decimal overflow shows up as a non-zero top nibble
  localparam int BCD_W = 4 * (NUM_DIGITS + 1);
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  // Wide enough that the hex overflow shift never reaches the full width
  localparam int EXT_W = BIN_WIDTH + 4 * NUM_DIGITS;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_WIDTH - 1);

  state_t                  r_state;
  state_t                  w_stateNext;
  logic [BCD_W-1:0]        r_bcd;
  logic [BIN_WIDTH-1:0]    r_bin;
  logic                    r_modeHex;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_overflow;
  logic [7*NUM_DIGITS-1:0] r_seg;

  logic                    w_accept;
  logic [BCD_W-1:0]        w_bcdAdj;
  logic [EXT_W-1:0]        w_valExt;
  logic                    w_ovfNext;
  logic                    w_higherZero;
  logic [7*NUM_DIGITS-1:0] w_segNext;
  logic [3:0]              w_digit [NUM_DIGITS];
  logic [6:0]              w_pat   [NUM_DIGITS];

  // A load is only taken in IDLE and not in the cycle the done pulse is showing
  assign w_accept = (r_state == IDLE) && load && !r_done;
  assign w_valExt = EXT_W'(r_bin);

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic: hex skips straight to UPDATE, decimal runs BIN_WIDTH dabble steps
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_stateNext = mode_hex ? UPDATE : CONV;
      CONV:    if (r_cnt == LAST_STEP) w_stateNext = UPDATE;
      UPDATE:  w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more before shifting
  always_comb begin
    w_bcdAdj = r_bcd;
    for (int i = 0; i < NUM_DIGITS + 1; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_bcdAdj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // Digit source: raw nibbles of the captured value in hex, finished BCD in decimal
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_digit[i] = r_modeHex ? w_valExt[4*i +: 4] : r_bcd[4*i +: 4];
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    hex7_decode u_dec (
      .i_nibble (w_digit[g]),
      .o_seg    (w_pat[g])
    );
  end

  // Overflow detection for both modes
  always_comb begin
    if (r_modeHex) begin
      w_ovfNext = ((w_valExt >> (4 * NUM_DIGITS)) != '0);
    end else begin
      w_ovfNext = (r_bcd[BCD_W-1 -: 4] != 4'd0);
    end
  end

  // Display mux, walking from the top digit down so leading zeros can be blanked
  always_comb begin
    w_segNext    = '1;
    w_higherZero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (w_ovfNext) begin
        w_segNext[7*i +: 7] = SEG_DASH;
      end else if ((BLANK_LEADING != 1'b0) && (i > 0) && w_higherZero && (w_digit[i] == 4'd0)) begin
        w_segNext[7*i +: 7] = SEG_BLANK;
      end else begin
        w_segNext[7*i +: 7] = w_pat[i];
      end
      if (w_digit[i] != 4'd0) begin
        w_higherZero = 1'b0;
      end
    end
  end

  // Datapath: capture on load, one shift per CONV cycle, register the display in UPDATE
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_bcd      <= '0;
      r_bin      <= '0;
      r_modeHex  <= 1'b0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_seg      <= '1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_bin     <= value;
            r_bcd     <= '0;
            r_modeHex <= mode_hex;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
          end
        end
        CONV: begin
          r_bcd <= {w_bcdAdj[BCD_W-2:0], r_bin[BIN_WIDTH-1]};
          r_bin <= {r_bin[BIN_WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        UPDATE: begin
          r_seg      <= w_segNext;
          r_overflow <= w_ovfNext;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_overflow;
  assign seg_out  = r_seg;

endmodule
